// File: rtl/decodificador_siete_segmentos_pkg.sv
// Shared seven-segment definitions: segment bit layout, hex decode table and default dwell.
// Used by the display-sniffing decoder and by the hex-to-seven-segment encoder.
package decodificador_siete_segmentos_pkg;

  localparam int ESTABLE_DEF = 4;
  localparam int NUM_DIGITOS = 4;

  // Segment a sits in the MSB and g in the LSB, as on the segmentos port.
  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
  } siete_t;

  localparam logic [6:0] TABLA_SIETE [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  function automatic logic [6:0] hex_a_siete(input logic [3:0] hex);
    return TABLA_SIETE[hex];
  endfunction

endpackage

// File: rtl/decodificador_siete_segmentos_siete_a_hex.sv
// Combinational reverse lookup of a lit-segment pattern into its hex value.
// Zero latency; patterns outside the table raise invalido with valor forced to 0.
module siete_a_hex
  import decodificador_siete_segmentos_pkg::*;
(
  input  logic [6:0] segmentos,
  output logic [3:0] valor,
  output logic       invalido
);

  always_comb begin
    valor    = 4'h0;
    invalido = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (segmentos == TABLA_SIETE[i]) begin
        valor    = 4'(i);
        invalido = 1'b0;
      end
    end
  end

endmodule

// File: rtl/decodificador_siete_segmentos.sv
// Recovers the 4-digit hex value from a multiplexed 7-segment display bus.
// Capture ESTABLE+1 cycles after pins settle, frame result 1 cycle later; no backpressure.
module decodificador_siete_segmentos
  import decodificador_siete_segmentos_pkg::*;
#(
  parameter int ESTABLE = ESTABLE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  segmentos,
  input  logic [3:0]  anodos,
  output logic [15:0] valor,
  output logic        valido,
  output logic        error,
  output logic [3:0]  capturados
);

  localparam int CW = $clog2(ESTABLE + 1);

  siete_t                           s1_seg;
  siete_t                           prev_seg;
  logic [3:0]                       s1_an;
  logic [3:0]                       prev_an;
  logic [CW-1:0]                    cuenta;
  logic [NUM_DIGITOS-1:0][3:0]      retenido;
  logic                             malo;

  logic                             estable;
  logic                             captura;
  logic                             fin_trama;
  logic [3:0]                       nibble;
  logic                             invalido;
  logic [3:0]                       capt_sig;
  logic                             malo_sig;

  siete_a_hex u_siete_a_hex (
    .segmentos (s1_seg),
    .valor     (nibble),
    .invalido  (invalido)
  );

  // Blanking (no anode) and multi-anode glitches never count as a stable dwell.
  assign estable   = (s1_seg == prev_seg) && (s1_an == prev_an) && $onehot(s1_an);
  // Fires on the single edge where the counter steps to ESTABLE-1; saturation blocks repeats.
  assign captura   = estable && (cuenta == CW'(ESTABLE - 2));
  assign fin_trama = (capturados == 4'b1111);

  // A capture landing on the frame-end cycle seeds the next frame.
  always_comb begin
    capt_sig = fin_trama ? 4'b0000 : capturados;
    malo_sig = fin_trama ? 1'b0 : malo;
    if (captura) begin
      capt_sig = capt_sig | s1_an;
      malo_sig = malo_sig | invalido;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_seg     <= '0;
      prev_seg   <= '0;
      s1_an      <= 4'b0000;
      prev_an    <= 4'b0000;
      cuenta     <= '0;
      retenido   <= '0;
      malo       <= 1'b0;
      valor      <= 16'h0000;
      valido     <= 1'b0;
      error      <= 1'b0;
      capturados <= 4'b0000;
    end else begin
      s1_seg   <= segmentos;
      s1_an    <= anodos;
      prev_seg <= s1_seg;
      prev_an  <= s1_an;

      if (!estable) begin
        cuenta <= '0;
      end else if (cuenta != CW'(ESTABLE)) begin
        cuenta <= cuenta + CW'(1);
      end

      valido <= fin_trama && !malo;
      error  <= fin_trama && malo;
      if (fin_trama && !malo) begin
        valor <= retenido;
      end

      capturados <= capt_sig;
      malo       <= malo_sig;

      if (captura && !invalido) begin
        for (int k = 0; k < NUM_DIGITOS; k++) begin
          if (s1_an[k]) begin
            retenido[k] <= nibble;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_decodificador_siete_segmentos.sv
// Bench: table-driven frames, hand sequences for dwell/reset/recapture, then random pin
// traffic, all checked cycle by cycle against a run-length reference model.
module tb_decodificador_siete_segmentos;

  localparam int EST = 4;

  logic        clk;
  logic        reset;
  logic [6:0]  segmentos;
  logic [3:0]  anodos;
  logic [15:0] valor;
  logic        valido;
  logic        error;
  logic [3:0]  capturados;

  decodificador_siete_segmentos #(.ESTABLE(EST)) dut (
    .clk        (clk),
    .reset      (reset),
    .segmentos  (segmentos),
    .anodos     (anodos),
    .valor      (valor),
    .valido     (valido),
    .error      (error),
    .capturados (capturados)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  int n_cmp = 0;
  int n_bad = 0;
  int n_val = 0;
  int n_err = 0;

  // Reference model: the pin stream seen as runs of identical one-hot samples.
  logic [6:0]  m_run_seg;
  logic [3:0]  m_run_an;
  int          m_run_len;
  logic [3:0]  m_capt;
  logic        m_malo;
  logic [3:0]  m_hold [4];
  logic [15:0] m_valor;
  logic        m_valido;
  logic        m_error;

  typedef struct packed {
    logic [3:0][6:0] pat;
    logic [15:0]     valor;
    logic            valido;
    logic            error;
  } vec_t;

  vec_t vecs [18];

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (seg_tab[i] == s) return {1'b0, 4'(i)};
    return 5'h10;
  endfunction

  task automatic chk(input string nombre, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nombre, $time, got, exp);
    end
  endtask

  task automatic model_edge(input logic [6:0] s, input logic [3:0] a, input logic r);
    logic       cap;
    logic       fin;
    logic       oh;
    logic [4:0] d;
    if (r) begin
      m_run_len = 0;
      m_capt    = 4'b0000;
      m_malo    = 1'b0;
      for (int k = 0; k < 4; k++) m_hold[k] = 4'h0;
      m_valor   = 16'h0000;
      m_valido  = 1'b0;
      m_error   = 1'b0;
    end else begin
      cap      = (m_run_len == EST);
      fin      = (m_capt == 4'hF);
      m_valido = fin && !m_malo;
      m_error  = fin && m_malo;
      if (m_valido) m_valor = {m_hold[3], m_hold[2], m_hold[1], m_hold[0]};
      if (fin) begin
        m_capt = 4'b0000;
        m_malo = 1'b0;
      end
      if (cap) begin
        d = ref_decode(m_run_seg);
        for (int k = 0; k < 4; k++) begin
          if (m_run_an == (4'b0001 << k)) begin
            m_capt[k] = 1'b1;
            if (!d[4]) m_hold[k] = d[3:0];
          end
        end
        if (d[4]) m_malo = 1'b1;
      end
      oh = (a == 4'b0001) || (a == 4'b0010) || (a == 4'b0100) || (a == 4'b1000);
      if (oh && m_run_len > 0 && s == m_run_seg && a == m_run_an)
        m_run_len = (m_run_len > EST) ? m_run_len : m_run_len + 1;
      else
        m_run_len = oh ? 1 : 0;
      m_run_seg = s;
      m_run_an  = a;
    end
  endtask

  task automatic step(input logic [6:0] s, input logic [3:0] a, input logic r);
    segmentos = s;
    anodos    = a;
    reset     = r;
    @(posedge clk);
    model_edge(s, a, r);
    #1;
    if (valido === 1'b1) n_val++;
    if (error === 1'b1) n_err++;
    chk("valor", valor, m_valor);
    chk("valido", valido, m_valido);
    chk("error", error, m_error);
    chk("capturados", capturados, m_capt);
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] a, input int n);
    for (int i = 0; i < n; i++) step(s, a, 1'b0);
  endtask

  task automatic send_frame(input logic [3:0][6:0] pat);
    for (int k = 0; k < 4; k++) hold(pat[k], 4'b0001 << k, 6);
    hold(7'h00, 4'b0000, 3);
  endtask

  initial begin
    logic [3:0] a;
    logic [6:0] s;
    int         r;

    segmentos = 7'h00;
    anodos    = 4'b0000;
    reset     = 1'b1;
    m_run_seg = 7'h00;
    m_run_an  = 4'b0000;
    m_run_len = 0;

    vecs[0] = '{pat: {7'h33, 7'h79, 7'h6D, 7'h30}, valor: 16'h4321, valido: 1'b1, error: 1'b0};
    vecs[1] = '{pat: {7'h33, 7'h79, 7'h00, 7'h30}, valor: 16'h4321, valido: 1'b0, error: 1'b1};
    for (int n = 0; n < 16; n++)
      vecs[2 + n] = '{pat: {4{seg_tab[n]}}, valor: {4{4'(n)}}, valido: 1'b1, error: 1'b0};

    for (int i = 0; i < 3; i++) step(7'h00, 4'b0000, 1'b1);
    chk("reset_valor", valor, 16'h0000);
    chk("reset_capturados", capturados, 4'b0000);

    for (int v = 0; v < 18; v++) begin
      n_val = 0;
      n_err = 0;
      send_frame(vecs[v].pat);
      chk("tabla_pulsos_valido", n_val, vecs[v].valido);
      chk("tabla_pulsos_error", n_err, vecs[v].error);
      chk("tabla_valor", valor, vecs[v].valor);
      chk("tabla_capturados", capturados, 4'b0000);
    end

    // Short dwell and a one-cycle double-anode glitch must not capture digit 1.
    n_val = 0;
    hold(7'h30, 4'b0001, 6);
    hold(7'h6D, 4'b0010, EST - 1);
    hold(7'h6D, 4'b0011, 1);
    hold(7'h6D, 4'b0010, 2);
    hold(7'h00, 4'b0000, 2);
    chk("corto_capturados", capturados, 4'b0001);
    hold(7'h6D, 4'b0010, 6);
    hold(7'h79, 4'b0100, 6);
    hold(7'h33, 4'b1000, 6);
    hold(7'h00, 4'b0000, 3);
    chk("corto_pulsos", n_val, 1);
    chk("corto_valor", valor, 16'h4321);

    // Reset with three digits captured discards the frame silently.
    n_val = 0;
    n_err = 0;
    hold(7'h30, 4'b0001, 6);
    hold(7'h6D, 4'b0010, 6);
    hold(7'h79, 4'b0100, 6);
    chk("mitad_capturados", capturados, 4'b0111);
    step(7'h79, 4'b0100, 1'b1);
    step(7'h79, 4'b0100, 1'b1);
    hold(7'h00, 4'b0000, 3);
    chk("rst_capturados", capturados, 4'b0000);
    chk("rst_valor", valor, 16'h0000);
    chk("rst_pulsos", n_val + n_err, 0);
    send_frame({7'h7F, 7'h70, 7'h5F, 7'h5B});
    chk("rst_siguiente_valor", valor, 16'h8765);
    chk("rst_siguiente_pulsos", n_val, 1);

    // Blanking between digits plus a recapture of digit 0.
    n_val = 0;
    hold(7'h30, 4'b0001, 6);
    hold(7'h00, 4'b0000, 3);
    hold(7'h6D, 4'b0010, 6);
    hold(7'h00, 4'b0000, 2);
    hold(7'h7F, 4'b0001, 6);
    hold(7'h00, 4'b0000, 1);
    hold(7'h79, 4'b0100, 6);
    hold(7'h33, 4'b1000, 6);
    hold(7'h00, 4'b0000, 3);
    chk("recaptura_valor", valor, 16'h4328);
    chk("recaptura_pulsos", n_val, 1);

    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 39));
      if (r == 0) begin
        step(7'h00, 4'b0000, 1'b1);
      end else begin
        a = 4'b0001 << $urandom_range(0, 3);
        if (r < 3) a = 4'($urandom_range(0, 15));
        s = seg_tab[$urandom_range(0, 15)];
        if (r == 3) s = 7'($urandom_range(0, 127));
        hold(s, a, int'($urandom_range(1, 7)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decodificador_siete_segmentos.md
DECODIFICADOR_SIETE_SEGMENTOS -- requirements
Module: decodificador_siete_segmentos

Interface
REQ-001 SHALL have parameter ESTABLE, default 4: consecutive identical cycles required before a digit is captured, minimum 2.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port segmentos, input, 7: lit segments, active-high; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
REQ-005 SHALL have port anodos, input, 4: digit select, active-high, one-hot; bit0=least-significant digit.
REQ-006 SHALL have port valor, output, 16: last good frame; digit k occupies bits 4k+3:4k.
REQ-007 SHALL have port valido, output, 1: one-cycle pulse; valor updated this cycle.
REQ-008 SHALL have port error, output, 1: one-cycle pulse; a frame completed containing an undecodable digit.
REQ-009 SHALL have port capturados, output, 4: mask of digits captured in the current frame.

Function
REQ-010 SHALL register segmentos and anodos once on input (stage S1) and compare them each cycle with the previous S1 sample.
REQ-011 SHALL clear the dwell counter whenever either the S1 sample differs from the previous sample or anodos is not one-hot (all-zero = blanking, multiple bits = glitch).
REQ-012 SHALL increment the dwell counter, saturating at ESTABLE, while the S1 sample is unchanged and one-hot.
REQ-013 SHALL capture the digit exactly once per dwell, in the cycle the counter reaches ESTABLE-1; longer dwells SHALL NOT recapture.
REQ-014 SHALL decode captures with the fixed table 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 B=1F C=4E D=3D E=4F F=47 (hex of segmentos).
REQ-015 SHALL treat any pattern outside the table as undecodable, set the frame's sticky malo flag, and still mark the digit captured.
REQ-016 SHALL overwrite that digit's holding nibble and set its capturados bit on a valid capture; recapturing an already-captured digit in the same frame SHALL overwrite it.
REQ-017 SHALL end the frame in the cycle after capturados becomes 4'b1111.
REQ-018 SHALL, at frame end when malo=0, load valor from the holding nibbles and pulse valido for one cycle.
REQ-019 SHALL, at frame end when malo=1, leave valor unchanged and pulse error for one cycle.
REQ-020 SHALL clear capturados and malo at frame end; a capture in that same cycle SHALL count toward the new frame.
REQ-021 SHALL never assert valido and error in the same cycle.
REQ-022 SHALL give a latency from the first stable sample at the pins to capture of ESTABLE+1 cycles, and from the final capture to valido/error of 1 cycle.

Reset
REQ-023 SHALL, while reset=1, set valor=16'h0000, valido=0, error=0, capturados=4'b0000, clear malo, the dwell counter, the S1 and previous-sample registers, and all holding nibbles.
REQ-024 SHALL discard any partially captured frame on reset mid-frame, with no valido or error pulse.
REQ-025 SHALL start a new dwell in the first cycle after reset is released.

Structure
REQ-026 SHALL define the decode table, the segment bit positions, and the ESTABLE default in a shared package, which the existing hex-to-seven-segment encoder SHALL also use.
REQ-027 SHALL contain one combinational sub-module, siete_a_hex (7-bit in -> 4-bit value plus invalid flag).

Verification
REQ-028 SHALL cover the full frame: digits 1,2,3,4 on anodos 0001..1000 with patterns 30,6D,79,33, each held 6 cycles -> one valido pulse, valor=16'h4321, error=0.
REQ-029 SHALL cover the bad pattern: as REQ-028, but digit 2 = 7'h00 -> error pulse, valor stays at its previous value, capturados cleared.
REQ-030 SHALL cover a short dwell: a pattern held ESTABLE-1 cycles and a 1-cycle anodos glitch (0011) -> no capture, capturados unchanged.
REQ-031 SHALL cover all 16 table entries: each applied across 4 digits -> valor = 16'hNNNN for each N.
REQ-032 SHALL cover reset mid-frame: reset after 3 digits captured -> no pulses, capturados=0; the next full frame decodes correctly.
REQ-033 SHALL cover blanking and recapture: anodos=0000 between digits is tolerated; digit 0 recaptured as 7F before frame end -> valor[3:0]=8.
